// File: rtl/pic_pkg.sv
// Shared constants and command decode for the pic_ctrl interrupt controller.
package pic_pkg;

  localparam logic [2:0] ADDR_IMR   = 3'd0;
  localparam logic [2:0] ADDR_VBASE = 3'd1;
  localparam logic [2:0] ADDR_ELCR  = 3'd2;
  localparam logic [2:0] ADDR_CMD   = 3'd3;
  localparam logic [2:0] ADDR_ISR   = 3'd4;

  localparam int CMD_NSEOI_BIT = 0;
  localparam int CMD_SEOI_BIT  = 1;

  localparam logic [2:0] SPUR_IDX      = 3'd7;
  localparam logic [7:0] PIC_DEF_VBASE = 8'h08;

  // Decoded view of a command-register write.
  typedef struct packed {
    logic       seoi;
    logic       nseoi;
    logic [2:0] lvl;
  } eoi_cmd_t;

  function automatic eoi_cmd_t decode_cmd(input logic [7:0] d);
    eoi_cmd_t c;
    c.seoi  = d[CMD_SEOI_BIT];
    c.nseoi = d[CMD_NSEOI_BIT];
    c.lvl   = d[6:4];
    return c;
  endfunction

endpackage

// File: rtl/pic_prio_enc.sv
// Lowest-index-wins priority encoder; idx is 0 when nothing is found.
module pic_prio_enc #(
  parameter int W = 8
) (
  input  logic [W-1:0] req,
  output logic         found,
  output logic [2:0]   idx
);

  // Scan high to low so the lowest set index is the last one written.
  always_comb begin
    found = 1'b0;
    idx   = 3'd0;
    for (int i = W - 1; i >= 0; i--) begin
      if (req[i]) begin
        found = 1'b1;
        idx   = 3'(i);
      end
    end
  end

endmodule

// File: rtl/pic_ctrl.sv
// Clocked interrupt controller: edge/level capture, masking, fixed priority
// against in-service levels, acknowledge/vector return and EOI retirement.
module pic_ctrl
  import pic_pkg::*;
#(
  parameter int         NUM_IRQ   = 8,
  parameter logic [7:0] DEF_VBASE = PIC_DEF_VBASE
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [NUM_IRQ-1:0] ir,
  input  logic               wr_en,
  input  logic               rd_en,
  input  logic [2:0]         addr,
  input  logic [7:0]         wdata,
  output logic [7:0]         rdata,
  input  logic               inta,
  output logic               int_out,
  output logic [7:0]         vector,
  output logic               vec_valid
);

  logic [NUM_IRQ-1:0] imr, elcr, irr, isr, ir_q;
  logic [4:0]         vbase_hi;

  logic [NUM_IRQ-1:0] prio_ok, elig, edge_set, eoi_clr, ack_set;
  logic [NUM_IRQ-1:0] irr_next, isr_next;
  logic               req_found, isr_found;
  logic [2:0]         req_idx, isr_idx;
  logic               cmd_wr;
  eoi_cmd_t           cmd;
  logic [7:0]         rd_mux;

  assign cmd_wr   = wr_en && (addr == ADDR_CMD);
  assign cmd      = decode_cmd(wdata);
  assign edge_set = ir & ~ir_q;

  // Highest in-service level (lowest set ISR index).
  pic_prio_enc #(.W(NUM_IRQ)) u_isr_enc (
    .req   (isr),
    .found (isr_found),
    .idx   (isr_idx)
  );

  // A request only competes if it outranks every level already in service.
  always_comb begin
    prio_ok = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      prio_ok[i] = !isr_found || (3'(i) < isr_idx);
  end

  assign elig = irr & ~imr & prio_ok;

  // Winner among eligible requests; also drives int_out.
  pic_prio_enc #(.W(NUM_IRQ)) u_req_enc (
    .req   (elig),
    .found (req_found),
    .idx   (req_idx)
  );

  // EOI clear mask and acknowledge set mask; specific EOI beats non-specific.
  always_comb begin
    eoi_clr = '0;
    ack_set = '0;
    for (int i = 0; i < NUM_IRQ; i++) begin
      if (cmd_wr && cmd.seoi)
        eoi_clr[i] = (cmd.lvl == 3'(i));
      else if (cmd_wr && cmd.nseoi)
        eoi_clr[i] = isr_found && (isr_idx == 3'(i));
      ack_set[i] = inta && req_found && (req_idx == 3'(i));
    end
  end

  // Next IRR/ISR: level lines track ir; edge lines keep a same-cycle new edge
  // even when acknowledged; acknowledge set wins over EOI clear.
  always_comb begin
    irr_next = '0;
    for (int i = 0; i < NUM_IRQ; i++)
      irr_next[i] = elcr[i] ? ir[i] : ((irr[i] & ~ack_set[i]) | edge_set[i]);
    isr_next = (isr & ~eoi_clr) | ack_set;
  end

  // Read data selection; unimplemented index bits read as zero.
  always_comb begin
    rd_mux = 8'h00;
    case (addr)
      ADDR_IMR:   rd_mux = 8'(imr);
      ADDR_VBASE: rd_mux = {vbase_hi, 3'b000};
      ADDR_ELCR:  rd_mux = 8'(elcr);
      ADDR_CMD:   rd_mux = 8'(irr);
      ADDR_ISR:   rd_mux = 8'(isr);
      default:    rd_mux = 8'h00;
    endcase
  end

  // State and registered outputs; resolution uses start-of-cycle values so a
  // concurrent register write only shows up next cycle.
  always_ff @(posedge clk) begin
    if (rst) begin
      imr       <= '1;
      vbase_hi  <= DEF_VBASE[7:3];
      elcr      <= '0;
      irr       <= '0;
      isr       <= '0;
      ir_q      <= '0;
      int_out   <= 1'b0;
      vector    <= 8'h00;
      vec_valid <= 1'b0;
      rdata     <= 8'h00;
    end else begin
      ir_q      <= ir;
      irr       <= irr_next;
      isr       <= isr_next;
      int_out   <= req_found;
      vec_valid <= inta;
      if (inta)
        vector <= {vbase_hi, req_found ? req_idx : SPUR_IDX};
      if (rd_en)
        rdata <= rd_mux;
      if (wr_en) begin
        case (addr)
          ADDR_IMR:   imr      <= wdata[NUM_IRQ-1:0];
          ADDR_VBASE: vbase_hi <= wdata[7:3];
          ADDR_ELCR:  elcr     <= wdata[NUM_IRQ-1:0];
          default:    ;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_pic_ctrl.sv
// Self-checking bench for pic_ctrl: directed scenarios plus a randomized run
// compared cycle by cycle against a behavioural model.
module tb_pic_ctrl;

  localparam int N = 8;

  logic         clk = 1'b0;
  logic         rst = 1'b1;
  logic [N-1:0] ir = '0;
  logic         wr_en = 1'b0, rd_en = 1'b0, inta = 1'b0;
  logic [2:0]   addr = 3'd0;
  logic [7:0]   wdata = 8'h00;
  logic [7:0]   rdata, vector;
  logic         int_out, vec_valid;

  int n_pass = 0;
  int n_total = 0;

  pic_ctrl #(.NUM_IRQ(N), .DEF_VBASE(8'h08)) dut (
    .clk(clk), .rst(rst), .ir(ir), .wr_en(wr_en), .rd_en(rd_en),
    .addr(addr), .wdata(wdata), .rdata(rdata), .inta(inta),
    .int_out(int_out), .vector(vector), .vec_valid(vec_valid)
  );

  always #5 clk = ~clk;

  // Behavioural model: whole registers as integers, current (m_) and next (n_).
  int m_imr = 255, m_vbase = 8, m_elcr = 0, m_irr = 0, m_isr = 0, m_irq = 0;
  int m_int = 0, m_vec = 0, m_vv = 0, m_rdata = 0;
  int n_imr, n_vbase, n_elcr, n_irr, n_isr, n_irq, n_int, n_vec, n_vv, n_rdata;

  function automatic int winner();
    int top = N;
    for (int i = N - 1; i >= 0; i--) if ((m_isr >> i) & 1) top = i;
    for (int i = 0; i < top; i++)
      if (((m_irr >> i) & 1) && !((m_imr >> i) & 1)) return i;
    return -1;
  endfunction

  task automatic model_eval();
    int w, bit_v;
    w = winner();
    n_imr = m_imr; n_vbase = m_vbase; n_elcr = m_elcr; n_irr = m_irr;
    n_isr = m_isr; n_irq = m_irq; n_int = m_int; n_vec = m_vec;
    n_vv = m_vv; n_rdata = m_rdata;
    if (rst) begin
      n_imr = 255; n_vbase = 8; n_elcr = 0; n_irr = 0; n_isr = 0; n_irq = 0;
      n_int = 0; n_vec = 0; n_vv = 0; n_rdata = 0;
    end else begin
      n_int = (w >= 0);
      n_vv  = inta;
      if (inta) n_vec = (m_vbase & 'hF8) | ((w < 0) ? 7 : w);
      if (rd_en)
        case (addr)
          0: n_rdata = m_imr;
          1: n_rdata = m_vbase;
          2: n_rdata = m_elcr;
          3: n_rdata = m_irr;
          4: n_rdata = m_isr;
          default: n_rdata = 0;
        endcase
      if (wr_en && addr == 3) begin
        if (wdata[1]) n_isr = n_isr & ~(1 << wdata[6:4]);
        else if (wdata[0]) n_isr = n_isr & (n_isr - 1);
      end
      if (inta && w >= 0) n_isr = n_isr | (1 << w);
      n_irr = 0;
      for (int i = 0; i < N; i++) begin
        if ((m_elcr >> i) & 1) bit_v = ir[i];
        else bit_v = ((((m_irr >> i) & 1) == 1) && !(inta && w == i)) ||
                     (ir[i] && !((m_irq >> i) & 1));
        n_irr = n_irr | (bit_v << i);
      end
      n_irq = int'(ir);
      if (wr_en && addr == 0) n_imr = wdata;
      if (wr_en && addr == 1) n_vbase = wdata & 'hF8;
      if (wr_en && addr == 2) n_elcr = wdata;
    end
  endtask

  // One clock: model evaluates from the inputs seen by the edge, then both advance.
  task automatic step();
    model_eval();
    @(posedge clk);
    m_imr = n_imr; m_vbase = n_vbase; m_elcr = n_elcr; m_irr = n_irr;
    m_isr = n_isr; m_irq = n_irq; m_int = n_int; m_vec = n_vec;
    m_vv = n_vv; m_rdata = n_rdata;
    #1;
  endtask

  task automatic do_reset();
    ir = '0; wr_en = 0; rd_en = 0; inta = 0; rst = 1;
    step();
    rst = 0;
    step();
  endtask

  task automatic wr(input logic [2:0] a, input logic [7:0] d);
    wr_en = 1; addr = a; wdata = d; step(); wr_en = 0;
  endtask

  task automatic rd(input logic [2:0] a, output logic [7:0] d);
    rd_en = 1; addr = a; step(); rd_en = 0; d = rdata;
  endtask

  task automatic ack();
    inta = 1; step(); inta = 0;
  endtask

  task automatic pulse(input logic [7:0] m);
    ir = ir | m; step(); ir = ir & ~m; step();
  endtask

  task automatic test_reset();
    logic [7:0] d;
    do_reset();
    n_total++; if (int_out !== 1'b0) $display("FAIL rst_int_out: got %b want 0", int_out); else n_pass++;
    n_total++; if (vec_valid !== 1'b0) $display("FAIL rst_vec_valid: got %b want 0", vec_valid); else n_pass++;
    n_total++; if (vector !== 8'h00) $display("FAIL rst_vector: got %h want 00", vector); else n_pass++;
    n_total++; if (rdata !== 8'h00) $display("FAIL rst_rdata: got %h want 00", rdata); else n_pass++;
    rd(3'd0, d); n_total++; if (d !== 8'hFF) $display("FAIL rst_imr: got %h want ff", d); else n_pass++;
    rd(3'd1, d); n_total++; if (d !== 8'h08) $display("FAIL rst_vbase: got %h want 08", d); else n_pass++;
    rd(3'd2, d); n_total++; if (d !== 8'h00) $display("FAIL rst_elcr: got %h want 00", d); else n_pass++;
  endtask

  task automatic test_basic();
    logic [7:0] d;
    do_reset();
    wr(3'd0, 8'hFE);
    ir = 8'h01; step();
    n_total++; if (int_out !== 1'b0) $display("FAIL basic_int_n1: got %b want 0", int_out); else n_pass++;
    step();
    n_total++; if (int_out !== 1'b1) $display("FAIL basic_int_n2: got %b want 1", int_out); else n_pass++;
    ir = '0; ack();
    n_total++; if (vector !== 8'h08) $display("FAIL basic_vector: got %h want 08", vector); else n_pass++;
    n_total++; if (vec_valid !== 1'b1) $display("FAIL basic_vv: got %b want 1", vec_valid); else n_pass++;
    step();
    n_total++; if (vec_valid !== 1'b0) $display("FAIL basic_vv_drop: got %b want 0", vec_valid); else n_pass++;
    rd(3'd4, d); n_total++; if (d !== 8'h01) $display("FAIL basic_isr: got %h want 01", d); else n_pass++;
    rd(3'd3, d); n_total++; if (d !== 8'h00) $display("FAIL basic_irr: got %h want 00", d); else n_pass++;
    n_total++; if (int_out !== 1'b0) $display("FAIL basic_int_off: got %b want 0", int_out); else n_pass++;
  endtask

  task automatic test_nested();
    logic [7:0] d;
    do_reset();
    wr(3'd0, 8'h00);
    pulse(8'h04); ack();
    n_total++; if (vector !== 8'h0A) $display("FAIL nest_vec2: got %h want 0a", vector); else n_pass++;
    pulse(8'h22);
    n_total++; if (int_out !== 1'b1) $display("FAIL nest_int: got %b want 1", int_out); else n_pass++;
    rd(3'd3, d); n_total++; if (d !== 8'h22) $display("FAIL nest_irr: got %h want 22", d); else n_pass++;
    ack();
    n_total++; if (vector !== 8'h09) $display("FAIL nest_vec1: got %h want 09", vector); else n_pass++;
    rd(3'd4, d); n_total++; if (d !== 8'h06) $display("FAIL nest_isr6: got %h want 06", d); else n_pass++;
    wr(3'd3, 8'h01);
    rd(3'd4, d); n_total++; if (d !== 8'h04) $display("FAIL nest_eoi: got %h want 04", d); else n_pass++;
    step();
    n_total++; if (int_out !== 1'b0) $display("FAIL nest_ir5_blocked: got %b want 0", int_out); else n_pass++;
  endtask

  task automatic test_level();
    logic [7:0] d;
    do_reset();
    wr(3'd0, 8'h00); wr(3'd2, 8'h08);
    ir = 8'h08; step(); step();
    n_total++; if (int_out !== 1'b1) $display("FAIL lvl_int: got %b want 1", int_out); else n_pass++;
    ack();
    n_total++; if (vector !== 8'h0B) $display("FAIL lvl_vec: got %h want 0b", vector); else n_pass++;
    step(); step();
    n_total++; if (int_out !== 1'b0) $display("FAIL lvl_int_insvc: got %b want 0", int_out); else n_pass++;
    rd(3'd3, d); n_total++; if (d !== 8'h08) $display("FAIL lvl_irr_held: got %h want 08", d); else n_pass++;
    wr(3'd3, 8'h01); step();
    n_total++; if (int_out !== 1'b1) $display("FAIL lvl_reassert: got %b want 1", int_out); else n_pass++;
    ir = 8'h00; step(); step();
    n_total++; if (int_out !== 1'b0) $display("FAIL lvl_int_low: got %b want 0", int_out); else n_pass++;
    rd(3'd3, d); n_total++; if (d !== 8'h00) $display("FAIL lvl_irr_low: got %h want 00", d); else n_pass++;
  endtask

  task automatic test_spurious();
    logic [7:0] d;
    do_reset();
    pulse(8'h10); step();
    n_total++; if (int_out !== 1'b0) $display("FAIL spur_int: got %b want 0", int_out); else n_pass++;
    ack();
    n_total++; if (vector !== 8'h0F) $display("FAIL spur_vec: got %h want 0f", vector); else n_pass++;
    n_total++; if (vec_valid !== 1'b1) $display("FAIL spur_vv: got %b want 1", vec_valid); else n_pass++;
    rd(3'd4, d); n_total++; if (d !== 8'h00) $display("FAIL spur_isr: got %h want 00", d); else n_pass++;
    rd(3'd3, d); n_total++; if (d !== 8'h10) $display("FAIL spur_irr: got %h want 10", d); else n_pass++;
  endtask

  task automatic test_conflict();
    logic [7:0] d;
    do_reset();
    wr(3'd0, 8'h00);
    pulse(8'h08); ack();
    pulse(8'h04);
    wr_en = 1; addr = 3'd3; wdata = 8'h32; inta = 1; step(); wr_en = 0; inta = 0;
    n_total++; if (vector !== 8'h0A) $display("FAIL cfl_vec: got %h want 0a", vector); else n_pass++;
    rd(3'd4, d); n_total++; if (d !== 8'h04) $display("FAIL cfl_isr_a: got %h want 04", d); else n_pass++;
    do_reset();
    wr(3'd0, 8'h00);
    pulse(8'h04);
    wr_en = 1; addr = 3'd3; wdata = 8'h22; inta = 1; step(); wr_en = 0; inta = 0;
    rd(3'd4, d); n_total++; if (d !== 8'h04) $display("FAIL cfl_isr_b: got %h want 04", d); else n_pass++;
    do_reset();
    wr(3'd0, 8'h00);
    pulse(8'h10);
    wr_en = 1; addr = 3'd0; wdata = 8'hFF; inta = 1; step(); wr_en = 0; inta = 0;
    n_total++; if (vector !== 8'h0C) $display("FAIL wack_vec: got %h want 0c", vector); else n_pass++;
    rd(3'd4, d); n_total++; if (d !== 8'h10) $display("FAIL wack_isr: got %h want 10", d); else n_pass++;
    rd(3'd0, d); n_total++; if (d !== 8'hFF) $display("FAIL wack_imr: got %h want ff", d); else n_pass++;
  endtask

  task automatic test_back_to_back();
    do_reset();
    wr(3'd0, 8'h00);
    ir = 8'h41; step(); ir = 8'h00; step();
    inta = 1; step();
    n_total++; if (vector !== 8'h08) $display("FAIL b2b_first: got %h want 08", vector); else n_pass++;
    wr_en = 1; addr = 3'd3; wdata = 8'h01; step(); wr_en = 0;
    n_total++; if (vector !== 8'h0F) $display("FAIL b2b_second: got %h want 0f", vector); else n_pass++;
    step(); inta = 0;
    n_total++; if (vector !== 8'h0E || vec_valid !== 1'b1) $display("FAIL b2b_third: got %h/%b want 0e/1", vector, vec_valid); else n_pass++;
  endtask

  task automatic test_vbase();
    logic [7:0] d;
    do_reset();
    wr(3'd1, 8'h73);
    rd(3'd1, d); n_total++; if (d !== 8'h70) $display("FAIL vbase_rd: got %h want 70", d); else n_pass++;
    wr(3'd4, 8'hFF); wr(3'd5, 8'hFF);
    rd(3'd4, d); n_total++; if (d !== 8'h00) $display("FAIL isr_ro: got %h want 00", d); else n_pass++;
    rd(3'd5, d); n_total++; if (d !== 8'h00) $display("FAIL addr5: got %h want 00", d); else n_pass++;
    wr(3'd0, 8'h00); pulse(8'h20); ack();
    n_total++; if (vector !== 8'h75) $display("FAIL vbase_vec: got %h want 75", vector); else n_pass++;
  endtask

  task automatic test_reset_mid();
    logic [7:0] d;
    do_reset();
    wr(3'd0, 8'h00); pulse(8'h01); rd(3'd1, d);
    inta = 1; rst = 1; step(); inta = 0; rst = 0;
    n_total++; if (vec_valid !== 1'b0) $display("FAIL rmid_vv_same: got %b want 0", vec_valid); else n_pass++;
    n_total++; if (rdata !== 8'h00) $display("FAIL rmid_rdata: got %h want 00", rdata); else n_pass++;
    wr(3'd0, 8'h00); pulse(8'h01); rd(3'd1, d);
    ack();
    n_total++; if (vec_valid !== 1'b1) $display("FAIL rmid_vv_pre: got %b want 1", vec_valid); else n_pass++;
    rst = 1; step(); rst = 0;
    n_total++; if (vec_valid !== 1'b0 || vector !== 8'h00 || int_out !== 1'b0 || rdata !== 8'h00)
      $display("FAIL rmid_outs: got vv=%b vec=%h int=%b rd=%h want 0/00/0/00", vec_valid, vector, int_out, rdata);
    else n_pass++;
    rd(3'd0, d); n_total++; if (d !== 8'hFF) $display("FAIL rmid_imr: got %h want ff", d); else n_pass++;
    rd(3'd4, d); n_total++; if (d !== 8'h00) $display("FAIL rmid_isr: got %h want 00", d); else n_pass++;
    rd(3'd3, d); n_total++; if (d !== 8'h00) $display("FAIL rmid_irr: got %h want 00", d); else n_pass++;
  endtask

  task automatic test_random();
    do_reset();
    for (int c = 0; c < 800; c++) begin
      rst   = ($urandom_range(0, 149) == 0);
      ir    = ir ^ N'($urandom & $urandom & $urandom);
      wr_en = ($urandom_range(0, 5) == 0);
      rd_en = ($urandom_range(0, 2) == 0);
      inta  = ($urandom_range(0, 3) == 0);
      addr  = 3'($urandom_range(0, 7));
      wdata = 8'($urandom);
      if (wr_en && addr == 3'd0) wdata = wdata & 8'($urandom);
      step();
      n_total++; if (int_out !== 1'(m_int)) $display("FAIL rnd_int c=%0d: got %b want %0d", c, int_out, m_int); else n_pass++;
      n_total++; if (vec_valid !== 1'(m_vv)) $display("FAIL rnd_vv c=%0d: got %b want %0d", c, vec_valid, m_vv); else n_pass++;
      n_total++; if (vector !== 8'(m_vec)) $display("FAIL rnd_vec c=%0d: got %h want %h", c, vector, 8'(m_vec)); else n_pass++;
      n_total++; if (rdata !== 8'(m_rdata)) $display("FAIL rnd_rdata c=%0d: got %h want %h", c, rdata, 8'(m_rdata)); else n_pass++;
    end
    rst = 0; wr_en = 0; rd_en = 0; inta = 0;
  endtask

  initial begin
    test_reset();
    test_basic();
    test_nested();
    test_level();
    test_spurious();
    test_conflict();
    test_back_to_back();
    test_vbase();
    test_reset_mid();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/pic_ctrl.md
# pic_ctrl

Parametrised, clocked successor to the asynchronous interrupt-request latch in the PC interrupt path. It captures up to `NUM_IRQ` request lines (edge or level per line), masks them, and resolves fixed priority against an in-service register. It raises `int_out` to the CPU, returns an 8-bit vector on an acknowledge pulse, and retires service on EOI commands written over a simple register port. It sits between peripheral IRQ lines (timer, keyboard, ...) and the CPU bus interface.

## Interface
- `NUM_IRQ`, 8: number of request lines, 1..8; line 0 has the highest priority.
- `DEF_VBASE`, 8'h08: reset value of the vector base register.
- `clk`  in  1  single system clock.
- `rst`  in  1  synchronous, active-high reset.
- `ir`  in  NUM_IRQ  request lines, already synchronous to `clk`.
- `wr_en`  in  1  register write strobe.
- `rd_en`  in  1  register read strobe.
- `addr`  in  3  register select.
- `wdata`  in  8  write data.
- `rdata`  out  8  registered read data.
- `inta`  in  1  one-cycle interrupt-acknowledge pulse from the CPU.
- `int_out`  out  1  interrupt request to the CPU.
- `vector`  out  8  interrupt vector.
- `vec_valid`  out  1  one-cycle strobe qualifying `vector`.

## Operation
- Register map:
  - 0: IMR, read/write, 1 = masked.
  - 1: VBASE, read/write; bits [2:0] read as 0.
  - 2: ELCR, read/write, 1 = level, 0 = edge.
  - 3: read IRR; write = command.
  - 4: read ISR; writes are ignored.
  - 5–7: read 0; writes are ignored.
- Command bits: bit0 = non-specific EOI, which clears the lowest-index set ISR bit. bit1 = specific EOI, which clears ISR[wdata[6:4]]. If both bits are set, the specific EOI wins. EOI with an empty ISR, or a specific EOI naming an out-of-range or clear bit, has no effect.
- IRR, edge line: set on `ir & ~ir_q`, where `ir_q` is the previous-cycle sample. Cleared when that line is acknowledged.
- IRR, level line: IRR bit equals `ir` each cycle. It is not cleared by acknowledge.
- Eligible set = IRR & ~IMR. A request may interrupt only if its index is lower than the lowest set ISR index (any index qualifies when ISR = 0).
- `int_out` is registered: it is 1 in the cycle after an eligible request exists, and drops the cycle after none exists.
- Acknowledge: an `inta` pulse in cycle N resolves the winner using the IRR, IMR and ISR values at the start of cycle N.
  - At N+1: `vector = {VBASE[7:3], idx[2:0]}` with `vec_valid = 1`.
  - The ISR bit for the winner is set; the IRR bit is cleared for an edge line.
- Spurious acknowledge (no eligible request at N): `vector = {VBASE[7:3], 3'd7}`, `vec_valid = 1`, ISR/IRR unchanged.
- Same-cycle conflicts:
  - EOI and acknowledge in one cycle: EOI clears first, then acknowledge sets. If the same ISR bit is affected, the set wins.
  - Edge capture and acknowledge of the same line in one cycle: IRR remains set.
  - A register write in the same cycle as an `inta` pulse takes effect from cycle N+1 and does not alter the resolution.
- Back-to-back `inta` pulses are serviced one per cycle.
- Reset values:
  - IMR = all ones (masked); VBASE = `DEF_VBASE`; ELCR = 0; IRR = 0; ISR = 0; `ir_q` = 0.
  - Outputs: `int_out` = 0, `vector` = 0, `vec_valid` = 0, `rdata` = 0.
  - Reset asserted mid-sequence cancels any pending `vec_valid` for the next cycle.
- Index bits at or above `NUM_IRQ` in IMR, ELCR, IRR and ISR read as 0 (IMR included) and cannot be set.

## Timing
- Edge on `ir` at cycle N: `ir_q` captures it at N+1, IRR is set at N+1, `int_out` = 1 at N+2.
- `rd_en` at cycle N: `rdata` is valid at N+1 and holds until the next read.
- `inta` at cycle N: `vector`/`vec_valid` at N+1; the ISR change is visible on a read issued at N+1 (data at N+2).
- After an ack that leaves no eligible request, `int_out` falls at N+2.
- IMR write at cycle N that masks the only request: `int_out` = 0 at N+2.

## Structure
- Package `pic_pkg`: register address constants, command bit positions, spurious index constant `3'd7`, default VBASE `8'h08`.
- Sub-module `pic_prio_enc`: parametrised lowest-index priority encoder with `found` and `idx` outputs. Instantiated twice: eligible-request resolution and highest in-service level.

## Test plan
- Reset, write IMR=0xFE, pulse `ir[0]` -> `int_out` = 1 two cycles after the edge; `inta` -> `vector` = 0x08, `vec_valid` for 1 cycle, ISR = 0x01, IRR = 0x00.
- ISR = 0x04 (IR2 in service), IRR gets IR5 and IR1 -> `int_out` = 1 due to IR1 only; ack -> `vector` = 0x09; non-specific EOI -> ISR = 0x04.
- Level line IR3 (ELCR = 0x08) held high, acked, EOI issued -> IRR stays 0x08, `int_out` re-asserts; IR3 held low -> IRR = 0.
- `inta` with all lines masked -> `vector` = 0x0F, ISR unchanged, `int_out` stays 0.
- Specific EOI (wdata = 0x22) in the same cycle as an ack of IR2 -> ISR bit 2 ends set; VBASE write 0x73 -> reads 0x70.
- `rst` asserted the cycle after `inta` -> `vec_valid` = 0; all registers and outputs return to their reset values.
